// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit with a fixed, parameterised busy latency per operation class.
// Optional build macro MD_DIV0_FLAG_EN adds the Div0 divide-by-zero pulse output.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Wr,
  input  logic [2:0]  MD_ctr,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
`ifdef MD_DIV0_FLAG_EN
  output logic        Div0,
`endif
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dbg_state
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2:0]     op_q, op_d;
  logic           div0_q, div0_d;

  logic           launch, commit, is_div_cmd;
  logic [63:0]    prod_s, prod_u;
  logic [31:0]    b_nz, q_u, r_u;
  logic signed [31:0] sa, sb, q_s, r_s;

  // Handshake: Start launches only from IDLE with an arithmetic code; Busy covers the
  // whole flight and results appear on HI/LO the first cycle Busy is low again.
  assign is_div_cmd = (MD_ctr == OP_DIV) || (MD_ctr == OP_DIVU);
  assign launch = (state_q == S_IDLE) && Start &&
                  (MD_ctr inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD});
  assign commit = (state_q == S_BUSY) && (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_BUSY;
      S_BUSY:  if (commit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divisor forced non-zero so the dividers never see 0; the zero case is skipped at commit.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    b_nz   = (b_q == 32'b0) ? 32'd1 : b_q;
    q_u    = a_q / b_nz;
    r_u    = a_q % b_nz;
    sa     = a_q;
    sb     = b_nz;
    if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
      q_s = 32'sh8000_0000;
      r_s = 32'sd0;
    end else begin
      q_s = sa / sb;
      r_s = sa % sb;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    div0_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (launch) begin
        a_d   = A;
        b_d   = B;
        op_d  = MD_ctr;
        cnt_d = is_div_cmd ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (Wr && !Start) begin
        if (MD_ctr == OP_MTHI) hi_d = A;
        if (MD_ctr == OP_MTLO) lo_d = A;
      end
    end else if (commit) begin
      cnt_d = '0;
      case (op_q)
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
        OP_DIV: begin
          if (b_q != 32'b0) begin
            lo_d = q_s;
            hi_d = r_s;
          end else div0_d = 1'b1;
        end
        OP_DIVU: begin
          if (b_q != 32'b0) begin
            lo_d = q_u;
            hi_d = r_u;
          end else div0_d = 1'b1;
        end
        default: ;
      endcase
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    Busy      = (state_q == S_BUSY);
    dbg_state = state_q;
    HI        = hi_q;
    LO        = lo_q;
`ifdef MD_DIV0_FLAG_EN
    Div0      = div0_q;
`endif
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level HI/LO model checked every cycle, directed
// cases with literal results, then randomized command traffic.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, Start, Wr;
  logic [2:0]  MD_ctr;
  logic [31:0] A, B, HI, LO;
  logic        Busy, dbg_state;
`ifdef MD_DIV0_FLAG_EN
  logic        Div0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Wr(Wr), .MD_ctr(MD_ctr),
    .A(A), .B(B), .Busy(Busy),
`ifdef MD_DIV0_FLAG_EN
    .Div0(Div0),
`endif
    .HI(HI), .LO(LO), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: whole-operation result computed at launch-time rules
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [2:0]  m_op;
  int          m_left;
  logic        m_div0, m_valid;

  function automatic logic [63:0] commit_value(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hilo);
    logic [31:0] ma, mb, q, r;
    longint      ps;
    ps = longint'($signed(a)) * longint'($signed(b));
    case (op)
      3'b000: return ps;
      3'b001: return {32'b0, a} * {32'b0, b};
      3'b110: return hilo + ps;
      3'b011: begin
        if (b == 0) return hilo;
        return {a % b, a / b};
      end
      3'b010: begin
        if (b == 0) return hilo;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q = ma / mb;
        r = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
      default: return hilo;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_div0 = 0; m_valid = 1;
    end else if (m_valid) begin
      m_div0 = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = commit_value(m_op, m_a, m_b, {m_hi, m_lo});
          m_div0 = (m_op inside {3'b010, 3'b011}) && (m_b == 0);
        end
      end else if (Start && (MD_ctr inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110})) begin
        m_op = MD_ctr; m_a = A; m_b = B;
        m_left = (MD_ctr inside {3'b010, 3'b011}) ? DC : MC;
      end else if (Wr && !Start) begin
        if (MD_ctr == 3'b100) m_hi = A;
        if (MD_ctr == 3'b101) m_lo = A;
      end
    end
  end

  // compare process: every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 64'(Busy), 64'(m_left > 0));
      check("dbg_state", 64'(dbg_state), 64'(m_left > 0));
      check("hi", 64'(HI), 64'(m_hi));
      check("lo", 64'(LO), 64'(m_lo));
`ifdef MD_DIV0_FLAG_EN
      check("div0", 64'(Div0), 64'(m_div0));
`endif
    end
  end

  // driver tasks
  task automatic wait_idle(input string name, input int exp_n);
    int n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_latency"}, 64'(n), 64'(exp_n));
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_n);
    @(negedge clk);
    Start = 1; MD_ctr = op; A = a; B = b;
    @(negedge clk);
    Start = 0;
    wait_idle(name, exp_n);
    check({name, "_result"}, {HI, LO}, exp_q.pop_front());
  endtask

  task automatic do_wr(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    Wr = 1; MD_ctr = op; A = a;
    @(negedge clk);
    Wr = 0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 9);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_valid = 0; m_left = 0; m_div0 = 0;
    reset = 1; Start = 0; Wr = 0; MD_ctr = 0; A = 0; B = 0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    reset = 0;

    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
    do_op("mult", 3'b000, 32'hFFFF_FFFD, 32'd5, MC);
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    do_op("multu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, DC);
    exp_q.push_back({32'h0000_0001, 32'h7FFF_FFFC});
    do_op("divu", 3'b011, 32'hFFFF_FFF9, 32'd2, DC);

    do_wr(3'b100, 32'h1234_5678);
    do_wr(3'b101, 32'h9);
    check("mthi_mtlo", {HI, LO}, {32'h1234_5678, 32'h9});

    // madd with a stray Start and Wr during Busy
    @(negedge clk);
    Start = 1; MD_ctr = 3'b110; A = 2; B = 3;
    @(negedge clk);
    MD_ctr = 3'b000; A = 32'h7; B = 32'h7;
    @(negedge clk);
    Start = 0; Wr = 1; MD_ctr = 3'b100;
    @(negedge clk);
    Wr = 0;
    wait_idle("madd", MC - 2);
    check("madd_result", {HI, LO}, {32'h1234_5678, 32'hF});

    exp_q.push_back({32'h1234_5678, 32'hF});
    do_op("div0", 3'b010, 32'd5, 32'd0, DC);
    exp_q.push_back({32'h0, 32'h8000_0000});
    do_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DC);

    // reset during the third Busy cycle of a divide
    @(negedge clk);
    Start = 1; MD_ctr = 3'b010; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_hilo", {HI, LO}, 64'd0);
    repeat (DC + 2) @(negedge clk);
    check("rst_no_commit", {HI, LO}, 64'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 199) == 0);
      Start  = ($urandom_range(0, 3) == 0);
      Wr     = ($urandom_range(0, 2) == 0);
      MD_ctr = 3'($urandom_range(0, 7));
      A      = pick_operand();
      B      = pick_operand();
      if (Start && (MD_ctr inside {3'b100, 3'b101, 3'b111})) Wr = 0;
    end
    @(negedge clk);
    reset = 0; Start = 0; Wr = 0;
    repeat (DC + 2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
